// File: rtl/nn_pkg.sv
// Shared types and lane arithmetic for the single-neuron evaluation engine.
package nn_pkg;

  localparam int LANES  = 4;
  localparam int LANE_W = 16;
  localparam int WORD_W = 64;

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  typedef logic [WORD_W-1:0] word_t;

  // Sum of the four signed 16x16 lane products, each sign-extended to 64 bits.
  function automatic word_t dot4(input word_t a, input word_t b);
    logic signed [2*LANE_W-1:0] prod;
    word_t                      sum;
    sum = '0;
    for (int i = 0; i < LANES; i++) begin
      prod = 32'(signed'(a[i*LANE_W +: LANE_W])) * 32'(signed'(b[i*LANE_W +: LANE_W]));
      sum  = sum + WORD_W'(prod);
    end
    return sum;
  endfunction

endpackage

// File: rtl/nn_eval_if.sv
// Push/start/pull bus between the NoC device interface (master) and nn_eval (slave).
interface nn_eval_if;
  import nn_pkg::*;

  word_t Din;
  logic  Push_data;
  logic  First_data;
  logic  Push_weight;
  logic  First_weight;
  logic  Start_calc;
  logic  Calculation_busy;
  logic  Calculation_complete;
  logic  Pull;
  logic  Empty;
  word_t Dout;

  modport master (
    output Din, Push_data, First_data, Push_weight, First_weight, Start_calc, Pull,
    input  Calculation_busy, Calculation_complete, Empty, Dout
  );

  modport slave (
    input  Din, Push_data, First_data, Push_weight, First_weight, Start_calc, Pull,
    output Calculation_busy, Calculation_complete, Empty, Dout
  );

endinterface

// File: rtl/nn_result_fifo.sv
// First-word-fall-through result FIFO; push and pull may coincide even when full.
module nn_result_fifo #(
  parameter int RES_DEPTH = 4,
  parameter int WIDTH     = 64
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             Push,
  input  logic [WIDTH-1:0] Din,
  input  logic             Pull,
  output logic             Empty,
  output logic             Full,
  output logic [WIDTH-1:0] Dout
);

  localparam int PW = (RES_DEPTH > 1) ? $clog2(RES_DEPTH) : 1;
  localparam int CW = $clog2(RES_DEPTH + 1);

  logic [WIDTH-1:0] mem [RES_DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic [CW-1:0]    count;
  logic             do_push;
  logic             do_pull;

  // Depth need not be a power of two, so pointers wrap explicitly.
  function automatic logic [PW-1:0] wrap_inc(input logic [PW-1:0] p);
    return (p == PW'(RES_DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  assign Empty   = (count == '0);
  assign Full    = (count == CW'(RES_DEPTH));
  assign do_pull = Pull && !Empty;
  assign do_push = Push && (!Full || do_pull);
  assign Dout    = Empty ? '0 : mem[rd_ptr];

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      // NOTE: non-blocking assignments so every flop samples pre-edge values.
      if (do_push) wr_ptr <= wrap_inc(wr_ptr);
      if (do_pull) rd_ptr <= wrap_inc(rd_ptr);
      case ({do_push, do_pull})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  // NOTE: storage is not reset; count gates visibility, so stale contents are harmless.
  always_ff @(posedge Clk) begin
    if (do_push) mem[wr_ptr] <= Din;
  end

endmodule

// File: rtl/nn_eval.sv
// Single-neuron dot-product engine: buffered weights/data, one word per CALC cycle,
// results queued in a FWFT FIFO for the device interface to drain.
module nn_eval
  import nn_pkg::*;
#(
  parameter int DEPTH     = 16,
  parameter int RES_DEPTH = 4,
  parameter bit RELU_EN   = 1'b0
) (
  input  logic       Clk,
  input  logic       Reset,
  nn_eval_if.slave   bus
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  word_t         data_mem   [DEPTH];
  word_t         weight_mem [DEPTH];
  logic [CW-1:0] data_count;
  logic [CW-1:0] weight_count;
  logic [CW-1:0] n_q;
  logic [CW-1:0] idx;
  logic [CW-1:0] n_next;
  state_t        state;
  word_t         acc;
  word_t         result;
  logic          busy_q;
  logic          complete_q;
  logic          idle;
  logic          wr_data;
  logic          wr_weight;
  logic [AW-1:0] data_addr;
  logic [AW-1:0] weight_addr;
  logic          fifo_full;
  logic          fifo_push;

  assign idle = (state == IDLE);

  // First always lands at index 0, even on a full buffer.
  assign wr_data     = bus.Push_data && idle && (bus.First_data || data_count < CW'(DEPTH));
  assign wr_weight   = bus.Push_weight && idle && (bus.First_weight || weight_count < CW'(DEPTH));
  assign data_addr   = bus.First_data   ? '0 : data_count[AW-1:0];
  assign weight_addr = bus.First_weight ? '0 : weight_count[AW-1:0];

  always_ff @(posedge Clk) begin
    if (wr_data)   data_mem[data_addr]     <= bus.Din;
    if (wr_weight) weight_mem[weight_addr] <= bus.Din;
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      data_count   <= '0;
      weight_count <= '0;
    end else begin
      if (wr_data)   data_count   <= bus.First_data   ? CW'(1) : data_count + CW'(1);
      if (wr_weight) weight_count <= bus.First_weight ? CW'(1) : weight_count + CW'(1);
    end
  end

  assign n_next    = (data_count < weight_count) ? data_count : weight_count;
  assign result    = (RELU_EN && acc[WORD_W-1]) ? '0 : acc;
  // A same-cycle Pull frees the slot the write needs; a full FIFO is never empty.
  assign fifo_push = (state == DONE) && (!fifo_full || bus.Pull);

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state      <= IDLE;
      n_q        <= '0;
      idx        <= '0;
      acc        <= '0;
      busy_q     <= 1'b0;
      complete_q <= 1'b0;
    end else begin
      complete_q <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.Start_calc) begin
            n_q    <= n_next;
            idx    <= '0;
            acc    <= '0;
            busy_q <= 1'b1;
            state  <= (n_next == '0) ? DONE : CALC;
          end
        end
        CALC: begin
          acc <= acc + dot4(data_mem[idx[AW-1:0]], weight_mem[idx[AW-1:0]]);
          idx <= idx + CW'(1);
          if (idx == n_q - CW'(1)) state <= DONE;
        end
        DONE: begin
          if (fifo_push) begin
            state      <= IDLE;
            busy_q     <= 1'b0;
            complete_q <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  nn_result_fifo #(
    .RES_DEPTH (RES_DEPTH),
    .WIDTH     (WORD_W)
  ) u_fifo (
    .Clk   (Clk),
    .Reset (Reset),
    .Push  (fifo_push),
    .Din   (result),
    .Pull  (bus.Pull),
    .Empty (bus.Empty),
    .Full  (fifo_full),
    .Dout  (bus.Dout)
  );

  assign bus.Calculation_busy     = busy_q;
  assign bus.Calculation_complete = complete_q;

endmodule

// File: tb/tb_nn_eval.sv
// Self-checking bench: plain-arithmetic dot-product model plus a result queue,
// driving a linear instance and a ReLU instance with identical stimulus.
module tb_nn_eval;
  import nn_pkg::*;

  localparam int DEPTH     = 16;
  localparam int RES_DEPTH = 4;

  logic Clk = 1'b0;
  logic Reset;
  always #5 Clk = ~Clk;

  nn_eval_if bus ();
  nn_eval_if bus_r ();

  assign bus_r.Din          = bus.Din;
  assign bus_r.Push_data    = bus.Push_data;
  assign bus_r.First_data   = bus.First_data;
  assign bus_r.Push_weight  = bus.Push_weight;
  assign bus_r.First_weight = bus.First_weight;
  assign bus_r.Start_calc   = bus.Start_calc;
  assign bus_r.Pull         = bus.Pull;

  nn_eval #(.DEPTH(DEPTH), .RES_DEPTH(RES_DEPTH), .RELU_EN(1'b0)) u_dut (
    .Clk(Clk), .Reset(Reset), .bus(bus));
  nn_eval #(.DEPTH(DEPTH), .RES_DEPTH(RES_DEPTH), .RELU_EN(1'b1)) u_relu (
    .Clk(Clk), .Reset(Reset), .bus(bus_r));

  int errors = 0;
  int checks = 0;

  word_t mw [DEPTH];
  word_t md [DEPTH];
  int    mwc = 0;
  int    mdc = 0;

  typedef struct { word_t v; word_t vr; } res_t;
  res_t exp_q [$];

  typedef struct {
    word_t w [3];
    int    nw;
    word_t d [3];
    int    nd;
    word_t exp_lin;
    word_t exp_relu;
  } vec_t;
  vec_t vt [3];

  task automatic check(input string name, input word_t act, input word_t exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  function automatic word_t ref_dot(input int n);
    longint s = 0;
    for (int k = 0; k < n; k++)
      for (int l = 0; l < LANES; l++)
        s += longint'(shortint'(md[k] >> (16 * l))) * longint'(shortint'(mw[k] >> (16 * l)));
    return word_t'(s);
  endfunction

  function automatic word_t ref_relu(input word_t v);
    return ($signed(v) < 0) ? '0 : v;
  endfunction

  function automatic word_t rand_word();
    case ($urandom_range(0, 3))
      0:       return {4{16'h8000}};
      1:       return {4{16'h7FFF}};
      default: return {$urandom, $urandom};
    endcase
  endfunction

  task automatic model_push(input bit is_data, input word_t w, input bit first);
    if (is_data) begin
      if (first) begin md[0] = w; mdc = 1; end
      else if (mdc < DEPTH) begin md[mdc] = w; mdc++; end
    end else begin
      if (first) begin mw[0] = w; mwc = 1; end
      else if (mwc < DEPTH) begin mw[mwc] = w; mwc++; end
    end
  endtask

  task automatic push(input bit is_data, input word_t w, input bit first);
    bus.Din = w;
    if (is_data) begin bus.Push_data = 1'b1; bus.First_data = first; end
    else begin bus.Push_weight = 1'b1; bus.First_weight = first; end
    tick();
    bus.Push_data = 1'b0; bus.First_data = 1'b0;
    bus.Push_weight = 1'b0; bus.First_weight = 1'b0;
    model_push(is_data, w, first);
  endtask

  task automatic push_both_first(input word_t w);
    bus.Din = w;
    bus.Push_data = 1'b1; bus.First_data = 1'b1;
    bus.Push_weight = 1'b1; bus.First_weight = 1'b1;
    tick();
    bus.Push_data = 1'b0; bus.First_data = 1'b0;
    bus.Push_weight = 1'b0; bus.First_weight = 1'b0;
    model_push(1'b1, w, 1'b1);
    model_push(1'b0, w, 1'b1);
  endtask

  task automatic check_head(input string name);
    if (exp_q.size() == 0) begin
      check({name, "_empty"}, 64'(bus.Empty), 64'd1);
      check({name, "_dout"}, bus.Dout, '0);
    end else begin
      check({name, "_empty"}, 64'(bus.Empty), 64'd0);
      check({name, "_dout"}, bus.Dout, exp_q[0].v);
      check({name, "_relu"}, bus_r.Dout, exp_q[0].vr);
    end
  endtask

  task automatic expect_result(input word_t r);
    res_t e;
    e.v  = r;
    e.vr = ref_relu(r);
    exp_q.push_back(e);
  endtask

  // Start, then expect busy for N+1 samples and the complete pulse on the next.
  task automatic run_calc(input string name);
    int    n;
    int    busy_cnt = 0;
    int    early = 0;
    word_t r;
    n = (mdc < mwc) ? mdc : mwc;
    r = ref_dot(n);
    bus.Start_calc = 1'b1;
    tick();
    bus.Start_calc = 1'b0;
    for (int i = 0; i <= n; i++) begin
      if (bus.Calculation_busy) busy_cnt++;
      if (bus.Calculation_complete) early++;
      tick();
    end
    check({name, "_busy_len"}, 64'(busy_cnt), 64'(n + 1));
    check({name, "_early_cmp"}, 64'(early), 64'd0);
    check({name, "_cmp"}, 64'(bus.Calculation_complete), 64'd1);
    check({name, "_busy_fall"}, 64'(bus.Calculation_busy), 64'd0);
    expect_result(r);
    check_head(name);
    tick();
    check({name, "_cmp_pulse"}, 64'(bus.Calculation_complete), 64'd0);
  endtask

  task automatic pull_one(input string name);
    bus.Pull = 1'b1;
    tick();
    bus.Pull = 1'b0;
    if (exp_q.size() > 0) exp_q.delete(0);
    check_head(name);
  endtask

  initial begin
    int    t;
    int    n;
    int    extra;
    int    bad;
    word_t r;

    bus.Din = '0;
    bus.Push_data = 1'b0; bus.First_data = 1'b0;
    bus.Push_weight = 1'b0; bus.First_weight = 1'b0;
    bus.Start_calc = 1'b0;
    bus.Pull = 1'b0;
    Reset = 1'b1;

    vt[0].w[0] = 64'h0004_0003_0002_0001; vt[0].nw = 1;
    vt[0].d[0] = 64'h0001_0001_0001_0001; vt[0].nd = 1;
    vt[0].exp_lin = 64'h0000_0000_0000_000A; vt[0].exp_relu = 64'h0000_0000_0000_000A;
    vt[1].w[0] = 64'h0000_0000_0000_FFFF; vt[1].nw = 1;
    vt[1].d[0] = 64'h0000_0000_0000_0005; vt[1].nd = 1;
    vt[1].exp_lin = 64'hFFFF_FFFF_FFFF_FFFB; vt[1].exp_relu = '0;
    for (int k = 0; k < 3; k++) vt[2].w[k] = 64'h0001_0001_0001_0001;
    for (int k = 0; k < 2; k++) vt[2].d[k] = 64'h0002_0002_0002_0002;
    vt[2].nw = 3; vt[2].nd = 2;
    vt[2].exp_lin = 64'd16; vt[2].exp_relu = 64'd16;

    #1;
    check("rst_busy", 64'(bus.Calculation_busy), 64'd0);
    check("rst_cmp", 64'(bus.Calculation_complete), 64'd0);
    check_head("rst");
    tick(); tick();
    Reset = 1'b0;
    tick();

    // Pull on empty is ignored; zero-length run yields 0 with minimal latency.
    pull_one("pull_empty");
    run_calc("zero_len");
    pull_one("zero_pop");

    for (int i = 0; i < 3; i++) begin
      for (int k = 0; k < vt[i].nw; k++) push(1'b0, vt[i].w[k], k == 0);
      for (int k = 0; k < vt[i].nd; k++) push(1'b1, vt[i].d[k], k == 0);
      run_calc($sformatf("vec%0d", i));
      check($sformatf("vec%0d_tbl", i), bus.Dout, vt[i].exp_lin);
      check($sformatf("vec%0d_tbl_relu", i), bus_r.Dout, vt[i].exp_relu);
      pull_one($sformatf("vec%0d_pop", i));
    end

    // Repeat start with retained buffers.
    run_calc("repeat");
    pull_one("repeat_pop");

    push_both_first(64'hFFFE_0003_8000_0007);
    run_calc("both_push");
    pull_one("both_pop");

    for (int it = 0; it < 12; it++) begin
      int nw;
      int nd;
      nw = $urandom_range(1, DEPTH + 2);
      nd = $urandom_range(1, DEPTH + 2);
      for (int k = 0; k < nw; k++) push(1'b0, rand_word(), k == 0);
      for (int k = 0; k < nd; k++) push(1'b1, rand_word(), k == 0);
      run_calc($sformatf("rnd%0d", it));
      pull_one($sformatf("rnd%0d_pop", it));
    end

    // FIFO full: four results queue, the fifth stalls in DONE until one Pull.
    for (int k = 0; k < 3; k++) push(1'b0, rand_word(), k == 0);
    for (int rr = 0; rr < RES_DEPTH; rr++) begin
      push(1'b1, rand_word(), 1'b1);
      run_calc($sformatf("fill%0d", rr));
    end
    push(1'b1, rand_word(), 1'b1);
    n = (mdc < mwc) ? mdc : mwc;
    r = ref_dot(n);
    bus.Start_calc = 1'b1;
    tick();
    bus.Start_calc = 1'b0;
    bad = 0;
    for (int i = 0; i < n + 6; i++) begin
      if (!bus.Calculation_busy || bus.Calculation_complete) bad++;
      tick();
    end
    check("full_stall", 64'(bad), 64'd0);
    check_head("full_head");
    bus.Pull = 1'b1;
    tick();
    bus.Pull = 1'b0;
    exp_q.delete(0);
    expect_result(r);
    check("full_release_cmp", 64'(bus.Calculation_complete), 64'd1);
    check("full_release_busy", 64'(bus.Calculation_busy), 64'd0);
    check_head("full_release");
    for (int k = 0; k < RES_DEPTH; k++) pull_one($sformatf("drain%0d", k));

    // Start and First-push during CALC must be ignored.
    for (int k = 0; k < 4; k++) push(1'b0, rand_word(), k == 0);
    for (int k = 0; k < 4; k++) push(1'b1, rand_word(), k == 0);
    n = 4;
    r = ref_dot(n);
    bus.Start_calc = 1'b1;
    tick();
    bus.Start_calc = 1'b0;
    tick();
    bus.Start_calc = 1'b1;
    bus.Push_data = 1'b1; bus.First_data = 1'b1;
    bus.Din = ~md[0];
    tick();
    bus.Start_calc = 1'b0;
    bus.Push_data = 1'b0; bus.First_data = 1'b0;
    t = 3;
    while (!bus.Calculation_complete && t < 30) begin
      tick();
      t++;
    end
    check("ign_latency", 64'(t), 64'(n + 2));
    expect_result(r);
    check_head("ign");
    extra = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (bus.Calculation_complete || bus.Calculation_busy) extra++;
    end
    check("ign_single", 64'(extra), 64'd0);
    pull_one("ign_pop");
    run_calc("ign_repeat");
    pull_one("ign_repeat_pop");

    // Reset during a 16-word run aborts it with no FIFO write.
    for (int k = 0; k < DEPTH + 2; k++) push(1'b0, rand_word(), k == 0);
    for (int k = 0; k < DEPTH + 2; k++) push(1'b1, rand_word(), k == 0);
    bus.Start_calc = 1'b1;
    tick();
    bus.Start_calc = 1'b0;
    for (int i = 0; i < 4; i++) tick();
    Reset = 1'b1;
    #1;
    check("mid_rst_busy", 64'(bus.Calculation_busy), 64'd0);
    check("mid_rst_cmp", 64'(bus.Calculation_complete), 64'd0);
    tick();
    Reset = 1'b0;
    mdc = 0;
    mwc = 0;
    exp_q.delete();
    bad = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (bus.Calculation_complete || bus.Calculation_busy || !bus.Empty) bad++;
    end
    check("mid_rst_quiet", 64'(bad), 64'd0);
    check_head("mid_rst");
    push(1'b1, 64'h0003_FFFF_0002_0010, 1'b0);
    push(1'b0, 64'h0005_0007_FFF0_0001, 1'b0);
    run_calc("post_rst");
    pull_one("post_rst_pop");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
